// File: rtl/ama_riscv_bp_gshare.sv
`default_nettype none
// ============================================================================
//  Module   : ama_riscv_bp_gshare
//  Purpose  : Bimodal/gshare branch direction predictor with a speculative GHR,
//             checkpoint repair on mispredict and saturating statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_bp_gshare #(
    parameter int PC_BITS   = 5,
    parameter int CNT_BITS  = 3,
    parameter int HIST_BITS = 4,
    parameter int IDX_LSB   = 2,
    parameter int MODE      = 1,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_vld_i,
    input  logic [31:0]          dec_pc_i,
    output logic                 pred_taken_o,
    output logic [HIST_BITS-1:0] pred_hist_o,
    input  logic                 res_vld_i,
    input  logic [31:0]          res_pc_i,
    input  logic [HIST_BITS-1:0] res_hist_i,
    input  logic                 res_taken_i,
    input  logic                 res_mispred_i,
    output logic [STAT_BITS-1:0] stat_pred_o,
    output logic [STAT_BITS-1:0] stat_mispred_o
);

    localparam int                  ENTRIES  = 1 << PC_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_THR  = CNT_MAX >> 1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_THR + CNT_BITS'(1);

    logic [CNT_BITS-1:0]  cnt_q [ENTRIES];
    logic [CNT_BITS-1:0]  cnt_d;
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] ghr_d;
    logic [STAT_BITS-1:0] stat_pred_q;
    logic [STAT_BITS-1:0] stat_mispred_q;
    logic [PC_BITS-1:0]   rd_idx;
    logic [PC_BITS-1:0]   wr_idx;
    logic                 repair;
    logic                 unused_pc_bits;

    function automatic logic [PC_BITS-1:0] idx_f(
        input logic [31:0]          pc,
        input logic [HIST_BITS-1:0] h
    );
        logic [PC_BITS-1:0] b;
        b = pc[PC_BITS+IDX_LSB-1:IDX_LSB];
        if (MODE != 0) begin
            b = b ^ PC_BITS'(h);
        end
        return b;
    endfunction

    assign unused_pc_bits = ^{dec_pc_i, res_pc_i};

    assign rd_idx = idx_f(dec_pc_i, ghr_q);
    assign wr_idx = idx_f(res_pc_i, res_hist_i);
    assign repair = res_vld_i & res_mispred_i;

    // Reads the registered table: a same-cycle train is not forwarded.
    assign pred_taken_o   = cnt_q[rd_idx] > CNT_THR;
    assign pred_hist_o    = ghr_q;
    assign stat_pred_o    = stat_pred_q;
    assign stat_mispred_o = stat_mispred_q;

    always_comb begin
        cnt_d = cnt_q[wr_idx];
        if (res_taken_i) begin
            if (cnt_q[wr_idx] != CNT_MAX) begin
                cnt_d = cnt_q[wr_idx] + CNT_BITS'(1);
            end
        end else if (cnt_q[wr_idx] != '0) begin
            cnt_d = cnt_q[wr_idx] - CNT_BITS'(1);
        end
    end

    // Truncating {h, bit} to HIST_BITS drops the oldest bit, and degenerates
    // to just the new bit when HIST_BITS is 1.
    always_comb begin
        ghr_d = ghr_q;
        if (repair) begin
            ghr_d = HIST_BITS'({res_hist_i, res_taken_i});
        end else if (dec_vld_i) begin
            ghr_d = HIST_BITS'({ghr_q, pred_taken_o});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (res_vld_i) begin
            cnt_q[wr_idx] <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Wrong-path decodes squashed by a same-cycle repair are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pred_q    <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (dec_vld_i && !repair && (stat_pred_q != '1)) begin
                stat_pred_q <= stat_pred_q + STAT_BITS'(1);
            end
            if (repair && (stat_mispred_q != '1)) begin
                stat_mispred_q <= stat_mispred_q + STAT_BITS'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_bp_gshare.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ama_riscv_bp_gshare
//  Purpose  : Scoreboard bench driving a gshare and a bimodal predictor in
//             lock-step against an array-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_bp_gshare;

    localparam int  C_ENTRIES = 32;
    localparam int  C_CNT_MAX = (1 << 3) - 1;
    localparam int  C_CNT_THR = C_CNT_MAX / 2;
    localparam int  C_CNT_INIT = C_CNT_THR + 1;
    localparam longint C_STAT_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_vld = 1'b0;
    logic [31:0] dec_pc = '0;
    logic        res_vld = 1'b0;
    logic [31:0] res_pc = '0;
    logic [3:0]  res_hist = '0;
    logic        res_taken = 1'b0;
    logic        res_mispred = 1'b0;

    logic        pt_g, pt_b;
    logic [3:0]  ph_g, ph_b;
    logic [31:0] sp_g, sp_b, sm_g, sm_b;

    ama_riscv_bp_gshare #(.MODE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .dec_vld_i(dec_vld), .dec_pc_i(dec_pc),
        .pred_taken_o(pt_g), .pred_hist_o(ph_g), .res_vld_i(res_vld),
        .res_pc_i(res_pc), .res_hist_i(res_hist), .res_taken_i(res_taken),
        .res_mispred_i(res_mispred), .stat_pred_o(sp_g), .stat_mispred_o(sm_g)
    );

    ama_riscv_bp_gshare #(.MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .dec_vld_i(dec_vld), .dec_pc_i(dec_pc),
        .pred_taken_o(pt_b), .pred_hist_o(ph_b), .res_vld_i(res_vld),
        .res_pc_i(res_pc), .res_hist_i(res_hist), .res_taken_i(res_taken),
        .res_mispred_i(res_mispred), .stat_pred_o(sp_b), .stat_mispred_o(sm_b)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit     pg;
        bit     pb;
        int     hg;
        int     hb;
        longint sp;
        longint sm;
    } exp_t;

    exp_t   exp_q[$];
    event   chk_ev;
    int     n_checks = 0;
    int     n_errors = 0;

    // Reference model: index 0 = bimodal, index 1 = gshare.
    int     cnt_m[2][C_ENTRIES];
    int     ghr_m[2];
    longint sp_m;
    longint sm_m;

    function automatic int idx_m(input int mode, input logic [31:0] pc, input int h);
        int base;
        base = int'(pc >> 2) % C_ENTRIES;
        return (mode == 1) ? (base ^ h) : base;
    endfunction

    function automatic bit pred_m(input int mode, input logic [31:0] pc);
        return cnt_m[mode][idx_m(mode, pc, ghr_m[mode])] > C_CNT_THR;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < C_ENTRIES; i++) cnt_m[m][i] = C_CNT_INIT;
            ghr_m[m] = 0;
        end
        sp_m = 0;
        sm_m = 0;
    endtask

    task automatic model_update();
        bit p[2];
        bit rep;
        int i;
        rep = res_vld && res_mispred;
        for (int m = 0; m < 2; m++) p[m] = pred_m(m, dec_pc);
        for (int m = 0; m < 2; m++) begin
            if (res_vld) begin
                i = idx_m(m, res_pc, int'(res_hist));
                if (res_taken) cnt_m[m][i] = (cnt_m[m][i] < C_CNT_MAX) ? cnt_m[m][i] + 1 : C_CNT_MAX;
                else           cnt_m[m][i] = (cnt_m[m][i] > 0) ? cnt_m[m][i] - 1 : 0;
            end
            if (rep)          ghr_m[m] = (int'(res_hist) * 2 + int'(res_taken)) % 16;
            else if (dec_vld) ghr_m[m] = (ghr_m[m] * 2 + int'(p[m])) % 16;
        end
        if (dec_vld && !rep && sp_m < C_STAT_MAX) sp_m++;
        if (rep && sm_m < C_STAT_MAX) sm_m++;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pg = pred_m(1, dec_pc);
        e.pb = pred_m(0, dec_pc);
        e.hg = ghr_m[1];
        e.hb = ghr_m[0];
        e.sp = sp_m;
        e.sm = sm_m;
        exp_q.push_back(e);
        -> chk_ev;
    endtask

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pred_taken_gshare", 64'(pt_g), 64'(e.pg));
                chk("pred_taken_bimodal", 64'(pt_b), 64'(e.pb));
                chk("pred_hist_gshare", 64'(ph_g), 64'(e.hg));
                chk("pred_hist_bimodal", 64'(ph_b), 64'(e.hb));
                chk("stat_pred_gshare", 64'(sp_g), 64'(e.sp));
                chk("stat_pred_bimodal", 64'(sp_b), 64'(e.sp));
                chk("stat_mispred_gshare", 64'(sm_g), 64'(e.sm));
                chk("stat_mispred_bimodal", 64'(sm_b), 64'(e.sm));
            end
        end
    end

    // One cycle of stimulus; mid_rst asserts reset between the check and the edge.
    task automatic step(input bit dv, input logic [31:0] dpc, input bit rv,
                        input logic [31:0] rpc, input logic [3:0] rh,
                        input bit rt, input bit rm, input bit mid_rst);
        @(negedge clk);
        dec_vld = dv; dec_pc = dpc; res_vld = rv; res_pc = rpc;
        res_hist = rh; res_taken = rt; res_mispred = rm;
        #1;
        push_exp();
        if (mid_rst) begin
            #3;
            rst_n = 1'b0;
            model_reset();
            #1;
            push_exp();
        end else if (rst_n) begin
            model_update();
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        dec_vld = 1'b0; res_vld = 1'b0; res_mispred = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // T1: reset state
        step(0, 32'h0000_0123, 0, 0, 0, 0, 0, 0);
        step(1, 32'h0000_0040, 1, 32'h40, 0, 0, 1, 0);
        release_reset();
        step(0, 32'h0000_1234, 0, 0, 0, 0, 0, 0);
        step(0, 32'h0000_0040, 0, 0, 0, 0, 0, 0);
        // T2: saturation on pc 0x40 up then down
        for (int i = 0; i < 6; i++) step(0, 32'h40, 1, 32'h40, 4'h0, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 32'h40, 1, 32'h40, 4'h0, 0, 0, 0);
        step(0, 32'h40, 0, 0, 0, 0, 0, 0);
        // T3: repair GHR to 0101, then the aliased gshare entry is untouched
        step(0, 32'h40, 1, 32'h00, 4'b0010, 1, 1, 0);
        step(0, 32'h40, 0, 0, 0, 0, 0, 0);
        // T4: clear GHR, three speculative shifts, then repair
        step(0, 32'h20, 1, 32'h80, 4'b0000, 0, 1, 0);
        step(1, 32'h20, 0, 0, 0, 0, 0, 0);
        step(1, 32'h24, 0, 0, 0, 0, 0, 0);
        step(1, 32'h28, 0, 0, 0, 0, 0, 0);
        step(0, 32'h2C, 1, 32'h2C, 4'b0001, 0, 1, 0);
        step(0, 32'h2C, 0, 0, 0, 0, 0, 0);
        // T5: decode + mispredict same cycle; train and predict same index
        step(1, 32'h30, 1, 32'h34, 4'b1001, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h50, 1, 32'h50, ghr_m[1][3:0], 0, 0, 0);
        step(0, 32'h50, 0, 0, 0, 0, 0, 0);
        // Randomised traffic over a small PC range to force aliasing
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom() & 32'hFC,
                 bit'($urandom_range(0, 3) != 0), $urandom() & 32'hFC,
                 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) == 0), 0);
        end
        // T6: asynchronous reset during active training
        step(1, 32'h44, 1, 32'h44, 4'h3, 1, 1, 1);
        release_reset();
        for (int i = 0; i < C_ENTRIES; i++) step(0, 32'(i * 4), 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom() & 32'h7C,
                 bit'($urandom_range(0, 1)), $urandom() & 32'h7C,
                 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 4) == 0), 0);
        end
        @(negedge clk);
        dec_vld = 1'b0; res_vld = 1'b0; res_mispred = 1'b0;
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
